// File: rtl/alu_sweep_engine_pkg.sv
// Shared types and widths for the ALU sweep engine: FSM state encoding and the
// widths of the function-code and overflow-count fields.
package alu_sweep_engine_pkg;

  localparam int ALU_F_W   = 3;
  localparam int OVF_CNT_W = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  // Running overflow tally; OPS <= 8 keeps this inside OVF_CNT_W bits.
  function automatic logic [OVF_CNT_W-1:0] ovf_add(input logic [OVF_CNT_W-1:0] cnt,
                                                   input logic ovf);
    return cnt + {{(OVF_CNT_W-1){1'b0}}, ovf};
  endfunction

endpackage

// File: rtl/alu_sweep_engine_if.sv
// Bundles the command, ALU drive/return and result stream of the sweep engine.
// Handshakes: a beat transfers on a rising edge where valid & ready are both 1;
// once valid is raised the source holds its payload stable until that transfer.
interface alu_sweep_engine_if #(
  parameter int N = 8
) ();
  import alu_sweep_engine_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [N-1:0]         cmd_a;
  logic [N-1:0]         cmd_b;

  logic [ALU_F_W-1:0]   alu_f;
  logic [N-1:0]         alu_a;
  logic [N-1:0]         alu_b;
  logic [N-1:0]         alu_y;
  logic                 alu_zero;
  logic                 alu_overflow;

  logic                 res_valid;
  logic                 res_ready;
  logic [ALU_F_W-1:0]   res_f;
  logic [N-1:0]         res_y;
  logic                 res_zero;
  logic                 res_overflow;
  logic                 res_last;
  logic [OVF_CNT_W-1:0] res_ovf_cnt;

  logic                 busy;
  state_e               dbg_state;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b,
    output cmd_ready,
    output alu_f, alu_a, alu_b,
    input  alu_y, alu_zero, alu_overflow,
    output res_valid, res_f, res_y, res_zero, res_overflow, res_last, res_ovf_cnt,
    input  res_ready,
    output busy, dbg_state
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b,
    input  cmd_ready,
    input  alu_f, alu_a, alu_b,
    output alu_y, alu_zero, alu_overflow,
    input  res_valid, res_f, res_y, res_zero, res_overflow, res_last, res_ovf_cnt,
    output res_ready,
    input  busy, dbg_state
  );

endinterface

// File: rtl/alu_sweep_engine_slot.sv
// One-entry valid/ready holding register for a captured ALU result. A load and a
// pop in the same cycle reload the entry without dropping valid.
module alu_result_slot #(
  parameter int N     = 8,
  parameter int F_W   = 3,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             pop_i,
  input  logic [F_W-1:0]   f_i,
  input  logic [N-1:0]     y_i,
  input  logic             zero_i,
  input  logic             ovf_i,
  input  logic             last_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic             free_o,
  output logic             valid_o,
  output logic [F_W-1:0]   f_o,
  output logic [N-1:0]     y_o,
  output logic             zero_o,
  output logic             ovf_o,
  output logic             last_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic             valid_q;
  logic [F_W-1:0]   f_q;
  logic [N-1:0]     y_q;
  logic             zero_q;
  logic             ovf_q;
  logic             last_q;
  logic [CNT_W-1:0] cnt_q;

  assign free_o = !valid_q || pop_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      f_q     <= '0;
      y_q     <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      f_q     <= f_i;
      y_q     <= y_i;
      zero_q  <= zero_i;
      ovf_q   <= ovf_i;
      last_q  <= last_i;
      cnt_q   <= cnt_i;
    end else if (pop_i) begin
      // Payload is left as-is; only valid matters once popped.
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign f_o     = f_q;
  assign y_o     = y_q;
  assign zero_o  = zero_q;
  assign ovf_o   = ovf_q;
  assign last_o  = last_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/alu_sweep_engine.sv
// Accepts an (A,B) command, walks the external ALU through F=0..OPS-1 and streams
// each Y/zero/overflow result out through a one-entry result slot.
module alu_sweep_engine
  import alu_sweep_engine_pkg::*;
#(
  parameter int N   = 8,
  parameter int OPS = 8
) (
  input  logic                clk,
  input  logic                rst,
  alu_sweep_engine_if.slave   bus
);

  localparam logic [ALU_F_W-1:0] F_LAST = ALU_F_W'(OPS - 1);

  state_e               state_q;
  logic [ALU_F_W-1:0]   alu_f_q;
  logic [N-1:0]         alu_a_q;
  logic [N-1:0]         alu_b_q;
  logic [OVF_CNT_W-1:0] cnt_q;
  logic [OVF_CNT_W-1:0] cnt_d;

  logic slot_free;
  logic load;
  logic f_last;

  assign f_last = (alu_f_q == F_LAST);
  assign load   = (state_q == ST_SWEEP) && slot_free;
  assign cnt_d  = ovf_add(cnt_q, bus.alu_overflow);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      alu_f_q <= '0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            alu_a_q <= bus.cmd_a;
            alu_b_q <= bus.cmd_b;
            alu_f_q <= '0;
            cnt_q   <= '0;
            state_q <= ST_SWEEP;
          end
        end
        ST_SWEEP: begin
          // A full, unconsumed slot stalls the sweep so no F is skipped.
          if (slot_free) begin
            cnt_q <= cnt_d;
            if (f_last) state_q <= ST_IDLE;
            else        alu_f_q <= alu_f_q + ALU_F_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE) && !rst;
  assign bus.busy      = (state_q == ST_SWEEP);
  assign bus.dbg_state = state_q;
  assign bus.alu_f     = alu_f_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;

  alu_result_slot #(
    .N     (N),
    .F_W   (ALU_F_W),
    .CNT_W (OVF_CNT_W)
  ) u_slot (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .pop_i   (bus.res_ready),
    .f_i     (alu_f_q),
    .y_i     (bus.alu_y),
    .zero_i  (bus.alu_zero),
    .ovf_i   (bus.alu_overflow),
    .last_i  (f_last),
    .cnt_i   (cnt_d),
    .free_o  (slot_free),
    .valid_o (bus.res_valid),
    .f_o     (bus.res_f),
    .y_o     (bus.res_y),
    .zero_o  (bus.res_zero),
    .ovf_o   (bus.res_overflow),
    .last_o  (bus.res_last),
    .cnt_o   (bus.res_ovf_cnt)
  );

endmodule

// File: tb/tb_alu_sweep_engine.sv
// Self-checking bench for alu_sweep_engine with a behavioural 8-bit ALU attached.
module tb_alu_sweep_engine;

  localparam int N     = 8;
  localparam int EXP_W = 18;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;

  logic [7:0]       ovf_mask;
  logic [EXP_W-1:0] exp_q[$];
  int               got_cyc[$];
  logic [3:0]       last_cnt;

  alu_sweep_engine_if #(.N(N)) bus ();

  alu_sweep_engine #(.N(N), .OPS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not complete");
  end

  // ---------------- ALU model: returns {ovf, zero, y} ----------------
  function automatic logic [9:0] alu_model(input logic [2:0] f, input logic [7:0] a,
                                           input logic [7:0] b);
    logic [7:0] y;
    logic       v;
    v = 1'b0;
    case (f)
      3'd0: begin y = a + b; v = (a[7] == b[7]) && (y[7] != a[7]); end
      3'd1: begin y = a - b; v = (a[7] != b[7]) && (y[7] != a[7]); end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: y = ~a;
      3'd6: begin y = {a[6:0], 1'b0}; v = a[7] ^ a[6]; end
      default: y = {1'b0, a[7:1]};
    endcase
    return {v, (y == 8'h00), y};
  endfunction

  logic [9:0] alu_r;
  always_comb begin
    alu_r            = alu_model(bus.alu_f, bus.alu_a, bus.alu_b);
    bus.alu_y        = alu_r[7:0];
    bus.alu_zero     = alu_r[8];
    bus.alu_overflow = alu_r[9] | ovf_mask[bus.alu_f];
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // expected entry: {f[3], last, y[8], zero, ovf, cnt[4]}
  task automatic push_sweep(input logic [7:0] a, input logic [7:0] b);
    logic [9:0] r;
    logic       o;
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int f = 0; f < 8; f++) begin
      r   = alu_model(3'(f), a, b);
      o   = r[9] | ovf_mask[f];
      cnt = cnt + {3'b0, o};
      exp_q.push_back({3'(f), (f == 7), r[7:0], r[8], o, cnt});
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (!rst && bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("res_f",        32'(bus.res_f),        32'(e[17:15]));
        check("res_last",     32'(bus.res_last),     32'(e[14]));
        check("res_y",        32'(bus.res_y),        32'(e[13:6]));
        check("res_zero",     32'(bus.res_zero),     32'(e[5]));
        check("res_overflow", 32'(bus.res_overflow), 32'(e[4]));
        if (e[14]) check("res_ovf_cnt", 32'(bus.res_ovf_cnt), 32'(e[3:0]));
        got_cyc.push_back(cyc);
        if (bus.res_last) last_cnt = bus.res_ovf_cnt;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, output int acc_cyc);
    int k;
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    k             = 0;
    acc_cyc       = -1;
    forever begin
      @(negedge clk);
      if (bus.cmd_ready === 1'b1) break;
      k++;
      if (k > 200) begin
        check("cmd_accept_timeout", 32'd0, 32'd1);
        bus.cmd_valid = 1'b0;
        return;
      end
    end
    acc_cyc = cyc;
    push_sweep(a, b);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = 8'($urandom_range(0, 255));
    bus.cmd_b     = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 || bus.res_valid !== 1'b0) begin
      @(posedge clk);
      #2;
      k++;
      if (k > 300) begin
        check(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        return;
      end
    end
  endtask

  task automatic wait_res_f(input logic [2:0] f);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (bus.res_valid === 1'b1 && bus.res_f === f) return;
    end
    check("wait_res_f_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int acc1, acc2, acc;
    n_checks      = 0;
    n_fail        = 0;
    ovf_mask      = 8'h00;
    last_cnt      = 4'd0;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = 8'h00;
    bus.cmd_b     = 8'h00;
    bus.res_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_res_valid", 32'(bus.res_valid),   32'd0);
    check("reset_busy",      32'(bus.busy),        32'd0);
    check("reset_cmd_ready", 32'(bus.cmd_ready),   32'd1);
    check("reset_alu_f",     32'(bus.alu_f),       32'd0);
    check("reset_alu_a",     32'(bus.alu_a),       32'd0);
    check("reset_alu_b",     32'(bus.alu_b),       32'd0);
    check("reset_res_last",  32'(bus.res_last),    32'd0);
    check("reset_ovf_cnt",   32'(bus.res_ovf_cnt), 32'd0);
    @(posedge clk);
    #1;

    // Single sweep followed immediately by a back-to-back command
    got_cyc.delete();
    send_cmd(8'h69, 8'h61, acc1);
    send_cmd(8'h19, 8'h1C, acc2);
    wait_drain("drain_b2b");
    check("b2b_count",       32'(got_cyc.size()), 32'd16);
    if (got_cyc.size() == 16) begin
      check("first_latency",  32'(got_cyc[0]),  32'(acc1 + 2));
      check("last_latency",   32'(got_cyc[7]),  32'(acc1 + 9));
      check("b2b_accept",     32'(acc2),        32'(acc1 + 9));
      check("b2b_gap",        32'(got_cyc[8]),  32'(got_cyc[7] + 2));
      check("b2b_last",       32'(got_cyc[15]), 32'(acc2 + 9));
    end

    // Back-pressure while F=3 is held in the slot
    send_cmd(8'h5A, 8'hC3, acc);
    wait_res_f(3'd3);
    bus.res_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_res_f",     32'(bus.res_f),     32'd3);
      check("bp_res_valid", 32'(bus.res_valid), 32'd1);
      check("bp_alu_f",     32'(bus.alu_f),     32'd4);
      check("bp_busy",      32'(bus.busy),      32'd1);
    end
    @(posedge clk);
    #1;
    bus.res_ready = 1'b1;
    wait_drain("drain_bp");

    // Forced overflow on F=1,4,6
    ovf_mask = 8'b0101_0010;
    last_cnt = 4'd0;
    send_cmd(8'h01, 8'h01, acc);
    wait_drain("drain_ovf");
    check("ovf_cnt_last", 32'(last_cnt), 32'd3);
    ovf_mask = 8'h00;

    // Command offered during a sweep is ignored
    got_cyc.delete();
    send_cmd(8'h3C, 8'h0F, acc);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = 8'hFF;
    bus.cmd_b     = 8'hFF;
    repeat (2) begin
      @(negedge clk);
      check("midsweep_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      check("midsweep_alu_a",     32'(bus.alu_a),     32'h3C);
      check("midsweep_alu_b",     32'(bus.alu_b),     32'h0F);
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    wait_drain("drain_midsweep");
    repeat (5) @(posedge clk);
    #1;
    check("midsweep_count",     32'(got_cyc.size()), 32'd8);
    check("midsweep_idle_busy", 32'(bus.busy),       32'd0);

    // Reset in the middle of a sweep
    send_cmd(8'h33, 8'h44, acc);
    for (int k = 0; k < 50; k++) begin
      if (bus.alu_f === 3'd5) break;
      @(posedge clk);
      #1;
    end
    check("pre_rst_alu_f", 32'(bus.alu_f), 32'd5);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("postrst_res_valid", 32'(bus.res_valid), 32'd0);
    check("postrst_busy",      32'(bus.busy),      32'd0);
    check("postrst_alu_f",     32'(bus.alu_f),     32'd0);
    check("postrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    got_cyc.delete();
    send_cmd(8'h00, 8'h00, acc);
    wait_drain("drain_postrst");
    check("postrst_count", 32'(got_cyc.size()), 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
